// File: rtl/lsr_sequencer_if.sv
// ---------------------------------------------------------------------------
// lsr_sequencer_if
// Command/response bundle between the ALSU front-end and lsr_sequencer.
//   req0_* / req1_* : two command channels (valid/ready, A, B, sel, count)
//   rsp_*           : registered result channel (valid/ready, id, data)
// Modports:
//   master : front-end side (drives commands, consumes responses)
//   slave  : sequencer side
// ---------------------------------------------------------------------------
interface lsr_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_sel;
  logic [CNT_W-1:0] req0_cnt;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_sel;
  logic [CNT_W-1:0] req1_cnt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sel, req0_cnt,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sel, req1_cnt,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel, req0_cnt,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sel, req1_cnt,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/lsr_sequencer.sv
// ---------------------------------------------------------------------------
// lsr_sequencer
// Arbitrates two command channels and applies the selected logic/shift/rotate
// operation 'cnt' times, feeding each datapath result back as the next A.
// The final value is returned on a registered valid/ready response.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lsr_sequencer_if.slave (commands in, response out)
//   busy       : high whenever the FSM is not IDLE
//   lsr_a/b    : datapath operands (accumulator / captured B)
//   lsr_sel    : datapath operation select (captured sel)
//   lsr_out    : combinational datapath result
//
// Configuration macro:
//   LSR_SEQ_RR_ARB_EN : round-robin arbitration between channels;
//                       undefined gives fixed priority to channel 0.
// ---------------------------------------------------------------------------
module lsr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  lsr_sequencer_if.slave    bus,
  output logic              busy,
  output logic [WIDTH-1:0]  lsr_a,
  output logic [WIDTH-1:0]  lsr_b,
  output logic [2:0]        lsr_sel,
  input  logic [WIDTH-1:0]  lsr_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] remaining;
  logic             id_q;

  logic             any_valid;
  logic             grant_id;
  logic             accept;

  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [2:0]       pick_sel;
  logic [CNT_W-1:0] pick_cnt;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign accept    = (state == IDLE) && any_valid;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef LSR_SEQ_RR_ARB_EN
  // rr_ptr names the channel that wins a tie; it moves to the other channel
  // after every accept, so a channel never wins two ties in a row.
  logic rr_ptr;

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_id = rr_ptr;
    else                                  grant_id = !bus.req0_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= 1'b0;
    else if (accept) rr_ptr <= ~grant_id;
  end
`else
  // Channel 0 always wins; channel 1 only when channel 0 is idle.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    grant_id = 1'b0;
    if (!bus.req0_valid) grant_id = 1'b1;
  end
`endif

  assign pick_a   = grant_id ? bus.req1_a   : bus.req0_a;
  assign pick_b   = grant_id ? bus.req1_b   : bus.req0_b;
  assign pick_sel = grant_id ? bus.req1_sel : bus.req0_sel;
  assign pick_cnt = grant_id ? bus.req1_cnt : bus.req0_cnt;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept)
              state_next = (pick_cnt == '0) ? RESP : EXEC;
      EXEC: if (remaining == CNT_W'(1))
              state_next = RESP;
      RESP: if (bus.rsp_ready)
              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy           = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req0_ready = any_valid && !grant_id;
        bus.req1_ready = any_valid &&  grant_id;
      end
      EXEC: busy = 1'b1;
      RESP: begin
        busy          = 1'b1;
        bus.rsp_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Command capture and iteration
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      remaining <= '0;
      id_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          acc       <= pick_a;
          b_q       <= pick_b;
          sel_q     <= pick_sel;
          remaining <= pick_cnt;
          id_q      <= grant_id;
        end
        // EXEC is entered only with remaining >= 1 and left at 1, so the
        // decrement never wraps.
        EXEC: begin
          acc       <= lsr_out;
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath and response are driven straight from registers: no
  // combinational path from req* reaches lsr_* or rsp_*.
  assign lsr_a        = acc;
  assign lsr_b        = b_q;
  assign lsr_sel      = sel_q;
  assign bus.rsp_data = acc;
  assign bus.rsp_id   = id_q;

endmodule

// File: tb/tb_lsr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lsr_sequencer
// Directed bench for lsr_sequencer with a rotate-left-by-1 datapath stub.
// A transaction-level model predicts ready/busy/response every cycle; the
// directed tasks pin the model with literal expected values and latencies.
// ---------------------------------------------------------------------------
module tb_lsr_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic [WIDTH-1:0] lsr_a;
  logic [WIDTH-1:0] lsr_b;
  logic [2:0]       lsr_sel;
  logic [WIDTH-1:0] lsr_out;

  lsr_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  lsr_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .lsr_a   (lsr_a),
    .lsr_b   (lsr_b),
    .lsr_sel (lsr_sel),
    .lsr_out (lsr_out)
  );

  // Datapath stub: rotate A left by one, whatever sel says.
  assign lsr_out = {lsr_a[WIDTH-2:0], lsr_a[WIDTH-1]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // -------------------------------------------------------------------------
  // Transaction-level model
  // -------------------------------------------------------------------------
  bit         m_idle = 1'b1;
  int         m_wait;       // cycles until the response appears
  logic [3:0] m_data;
  logic       m_id;
  logic [3:0] m_b;
  logic [2:0] m_sel;
  logic       m_ptr = 1'b0; // channel favoured on a tie (round-robin only)

  function automatic logic [3:0] rotl(input logic [3:0] a, input int n);
    int k;
    int v;
    k = n % 4;
    v = int'(a);
    return 4'(((v << k) | (v >> (4 - k))) & 15);
  endfunction

  function automatic logic model_grant(input logic v0, input logic v1, input logic ptr);
`ifdef LSR_SEQ_RR_ARB_EN
    if (v0 && v1) return ptr;
    return !v0;
`else
    return !v0;
`endif
  endfunction

  always @(negedge clk) begin
    logic g;
    logic any;
    if (!rst_n) begin
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", {bus.req0_ready, bus.req1_ready}, 0);
      check("rst_rsp", {bus.rsp_id, bus.rsp_data}, 0);
      check("rst_lsr", {lsr_a, lsr_b, lsr_sel}, 0);
      m_idle = 1'b1;
      m_ptr  = 1'b0;
    end else begin
      any = bus.req0_valid | bus.req1_valid;
      g   = model_grant(bus.req0_valid, bus.req1_valid, m_ptr);
      check("m_ready0", bus.req0_ready, m_idle && any && !g);
      check("m_ready1", bus.req1_ready, m_idle && any &&  g);
      check("m_busy", busy, !m_idle);
      check("m_rsp_valid", bus.rsp_valid, !m_idle && m_wait == 0);
      if (!m_idle) begin
        check("m_lsr_b", lsr_b, m_b);
        check("m_lsr_sel", lsr_sel, m_sel);
        if (m_wait == 0) begin
          check("m_rsp_data", bus.rsp_data, m_data);
          check("m_rsp_id", bus.rsp_id, m_id);
        end
      end
      // advance to the next cycle using inputs stable across the coming edge
      if (m_idle) begin
        if (any) begin
          m_idle = 1'b0;
          m_id   = g;
          m_wait = int'(g ? bus.req1_cnt : bus.req0_cnt);
          m_data = rotl(g ? bus.req1_a : bus.req0_a, m_wait);
          m_b    = g ? bus.req1_b : bus.req0_b;
          m_sel  = g ? bus.req1_sel : bus.req0_sel;
          m_ptr  = !g;
        end
      end else if (m_wait > 0) begin
        m_wait--;
      end else if (bus.rsp_ready) begin
        m_idle = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus
  // -------------------------------------------------------------------------
  task automatic drive(input bit ch, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] sel, input logic [2:0] cnt);
    if (!ch) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_cnt = cnt;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_cnt = cnt;
    end
  endtask

  // Waits (bounded) for the channel's ready at a negedge; leaves valid high.
  task automatic wait_accept(input bit ch);
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      ok = ch ? bus.req1_ready : bus.req0_ready;
    end
    check("accept_seen", ok, 1);
  endtask

  task automatic run_cmd(input bit ch, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] sel, input logic [2:0] cnt, input int hold,
                         input logic [3:0] exp_data, input int exp_lat);
    int lat;
    logic [3:0] d0;
    logic       i0;
    @(posedge clk); #1;
    bus.rsp_ready = (hold == 0);
    drive(ch, 1'b1, a, b, sel, cnt);
    wait_accept(ch);
    @(posedge clk); #1;
    drive(ch, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    check("latency", lat, exp_lat);
    check("rsp_data", bus.rsp_data, exp_data);
    check("rsp_id", bus.rsp_id, ch);
    if (hold > 0) begin
      d0 = bus.rsp_data;
      i0 = bus.rsp_id;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_valid", bus.rsp_valid, 1);
        check("hold_stable", {bus.rsp_id, bus.rsp_data}, {i0, d0});
        check("hold_busy", busy, 1);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("back_idle", {bus.rsp_valid, busy}, 0);
  endtask

  task automatic arb_test();
    int   ng;
    int   n;
    logic grants [3];
    int   exp_g  [3];
`ifdef LSR_SEQ_RR_ARB_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'b0001, 4'h2, 3'd1, 3'd0);
    drive(1'b1, 1'b1, 4'b1000, 4'h4, 3'd2, 3'd0);
    ng = 0;
    n  = 0;
    while (ng < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (bus.req0_ready || bus.req1_ready) begin
        grants[ng] = bus.req1_ready;
        ng++;
      end
    end
    check("arb_count", ng, 3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    repeat (3) @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      if (i < ng) check($sformatf("grant%0d", i), grants[i], exp_g[i]);
  endtask

  task automatic reset_mid_exec();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b1, 4'b0001, 4'b1111, 3'b101, 3'd5);
    wait_accept(1'b0);
    @(posedge clk); #1;                // EXEC cycle 1
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    @(posedge clk); #3;                // inside EXEC cycle 2
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", bus.rsp_valid, 0);
    check("async_rst_lsr", {lsr_a, lsr_b, lsr_sel}, 0);
    check("async_rst_rsp", {bus.rsp_id, bus.rsp_data}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("no_rsp_after_rst", {bus.rsp_valid, busy}, 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 3'h0, 3'h0);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // a=0011 rotated twice -> 1100, response 3 cycles after accept
    run_cmd(1'b0, 4'b0011, 4'b0110, 3'd3, 3'd2, 0, 4'b1100, 3);
    // cnt=0: data returned unchanged after 1 cycle
    run_cmd(1'b1, 4'b1010, 4'b0001, 3'd4, 3'd0, 0, 4'b1010, 1);
    // back-pressure for 5 cycles: 0101 rotated 3 times -> 1010
    run_cmd(1'b1, 4'b0101, 4'b1001, 3'd6, 3'd3, 5, 4'b1010, 4);
    arb_test();
    reset_mid_exec();
    // fresh cnt=1 command after reset: 0110 -> 1100
    run_cmd(1'b0, 4'b0110, 4'b0011, 3'd2, 3'd1, 0, 4'b1100, 2);
    // full count: 0001 rotated 7 times -> 1000 after 8 cycles
    run_cmd(1'b0, 4'b0001, 4'b1110, 3'd7, 3'd7, 0, 4'b1000, 8);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/lsr_sequencer.md
# lsr_sequencer

Sequencing controller for the 4-bit logic/shift/rotate unit. It arbitrates between two command requesters and applies the selected operation iteratively for a programmable count, feeding each result back as the next A operand. Each result is returned through a registered valid/ready response port. It sits between the ALSU command front-end and the combinational logic/shift/rotate datapath, which it drives through dedicated operand and select ports.

## Interface
Parameters:
- WIDTH, 4, operand/result width; must match the datapath.
- CNT_W, 3, iteration-count field width; 0 to 2^CNT_W-1 iterations.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  command present on channel 0 / 1.
- req0_ready / req1_ready  output  1  command accepted this cycle.
- req0_a / req1_a  input  WIDTH  initial A operand.
- req0_b / req1_b  input  WIDTH  B operand, constant across iterations.
- req0_sel / req1_sel  input  3  datapath operation select.
- req0_cnt / req1_cnt  input  CNT_W  iteration count.
- rsp_valid  output  1  response pending.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  channel that issued the command.
- rsp_data  output  WIDTH  final result.
- busy  output  1  high in any state other than IDLE.
- lsr_a  output  WIDTH  datapath A, driven from the accumulator register.
- lsr_b  output  WIDTH  datapath B, driven from the captured B.
- lsr_sel  output  3  datapath select, driven from the captured sel.
- lsr_out  input  WIDTH  combinational datapath result.

## Operation
- FSM states and transitions:
  - IDLE: if any reqN_valid is high, grant one channel, then go to EXEC if cnt != 0, or to RESP if cnt == 0.
  - EXEC: go to RESP when remaining == 1.
  - RESP: go to IDLE when rsp_ready is high.
- Arbitration happens only in IDLE:
  - reqN_ready is asserted combinationally, for the granted channel only, and only while the FSM is in IDLE.
  - At most one ready is high per cycle.
  - Fixed priority: channel 0 wins when both channels are valid (see Configuration).
- Accept (valid & ready):
  - Capture acc <= a, b, sel, remaining <= cnt, id <= channel.
  - If cnt == 0, rsp_data = a unchanged.
- EXEC, each cycle:
  - acc <= lsr_out and remaining <= remaining - 1.
  - Exactly cnt datapath evaluations occur.
- RESP:
  - rsp_valid = 1; rsp_data = acc; rsp_id = id.
  - All three are held stable until rsp_ready is high.
  - The transfer completes on the cycle where rsp_valid & rsp_ready.
- Requesters are not accepted while busy; the non-granted channel waits with valid held.
- lsr_a, lsr_b and lsr_sel always reflect the registered values. There are no combinational paths from req* to lsr_*.

## Timing
- Reset value of every output, plus internal state (asserted asynchronously, released synchronously to clk):
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0, req*_ready = 0.
  - lsr_a = 0, lsr_b = 0, lsr_sel = 0.
  - State = IDLE; round-robin pointer favours channel 0.
- Latency, with accept in cycle t:
  - rsp_valid rises in cycle t+cnt+1.
  - cnt = 0 gives 1 cycle; cnt = 7 gives 8 cycles.
- Throughput: one bubble cycle in IDLE after each response. The earliest next accept is the cycle after the rsp handshake.
- rsp_ready held high on rsp_valid rise: the transfer completes that same cycle and the FSM is in IDLE on the next cycle.
- Reset mid-EXEC or mid-RESP: the command is dropped, no response is issued, and all outputs return to their reset values immediately.
- Counter arithmetic is unsigned CNT_W-bit. remaining never wraps, because EXEC exits at 1.

## Configuration
- LSR_SEQ_RR_ARB_EN defined: round-robin arbitration.
  - When both channels are valid, the channel not granted last wins.
  - The pointer updates on every accept.
  - A single valid channel is always granted.
- Undefined: fixed priority, with channel 0 always winning. The pointer logic is removed.

## Test plan
Bench stub for all scenarios: lsr_out = rotate-left-by-1 of lsr_a, for any sel.
- req0: a=4'b0011, cnt=2 -> rsp_valid 3 cycles after accept; rsp_data=4'b1100, rsp_id=0.
- req1: a=4'b1010, cnt=0 -> rsp_valid 1 cycle after accept; rsp_data=4'b1010, rsp_id=1; zero EXEC cycles.
- rsp_ready held low for 5 cycles -> rsp_data and rsp_id stable; both req*_ready stay 0; busy=1 throughout.
- Both channels valid for 3 back-to-back commands:
  - Without the macro -> grants 0,0,0.
  - With LSR_SEQ_RR_ARB_EN -> grants 0,1,0.
- rst_n pulsed low in the 2nd EXEC cycle of a cnt=5 command -> all outputs 0 asynchronously; no response; a fresh cnt=1 command afterwards completes normally.
- cnt=7 with a=4'b0001 -> rsp_data=4'b1000 after 8 cycles; verifies full-count boundary with no counter wrap.
